// File: rtl/fft_if.sv
// Host-side bus of the 8-point FFT core: frame start, sample stream,
// result read port and completion flag.
interface fft_if #(
    parameter int DW = 24
);
    logic                 initial_en;
    logic signed [DW-1:0] datain_re;
    logic signed [DW-1:0] datain_im;
    logic [2:0]           read_addr;
    logic signed [DW-1:0] dataout_re;
    logic signed [DW-1:0] dataout_im;
    logic                 fft_finish;

    modport master (
        output initial_en, datain_re, datain_im, read_addr,
        input  dataout_re, dataout_im, fft_finish
    );

    modport slave (
        input  initial_en, datain_re, datain_im, read_addr,
        output dataout_re, dataout_im, fft_finish
    );
endinterface

// File: rtl/fft_top.sv
// 8-point radix-2 DIT FFT on complex 24-bit samples, computed in place in a
// register-based 8-entry RAM, one butterfly per clock.
//
// state | meaning
// IDLE  | waiting for initial_en after reset
// GAP   | one dead cycle after the start pulse, nothing captured
// LOAD  | 8 samples captured, x[n] written to address bitrev3(n)
// CALC  | 3 stages x 4 butterflies, cnt_q[3:2] = stage, cnt_q[1:0] = butterfly
// DONE  | results valid, fft_finish raised on the first DONE edge
module fft_top (
    input  logic   clk,
    input  logic   rst,
    fft_if.slave   bus
);
    localparam int DW = 24;
    localparam int TW = 16;

    typedef enum logic [2:0] {IDLE, GAP, LOAD, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 finish_q, finish_d;
    logic signed [DW-1:0] dout_re_q, dout_re_d;
    logic signed [DW-1:0] dout_im_q, dout_im_d;
    logic signed [DW-1:0] mem_re_q [8];
    logic signed [DW-1:0] mem_re_d [8];
    logic signed [DW-1:0] mem_im_q [8];
    logic signed [DW-1:0] mem_im_d [8];

    logic [1:0]           stage;
    logic [1:0]           bf;
    logic [2:0]           a_idx, b_idx;
    logic [1:0]           tw_k;
    logic signed [TW-1:0] w_re, w_im;
    logic signed [39:0]   t_re_full, t_im_full;
    logic signed [DW-1:0] t_re, t_im;
    logic signed [DW-1:0] a_re, a_im, b_re, b_im;
    logic [2:0]           load_addr;

    assign stage     = cnt_q[3:2];
    assign bf        = cnt_q[1:0];
    assign load_addr = {cnt_q[0], cnt_q[1], cnt_q[2]};

    // Operand addresses and twiddle index for the current butterfly
    always_comb begin
        a_idx = 3'd0;
        tw_k  = 2'd0;
        case (stage)
            2'd0: begin
                a_idx = {bf, 1'b0};
                tw_k  = 2'd0;
            end
            2'd1: begin
                a_idx = {bf[1], 1'b0, bf[0]};
                tw_k  = {bf[0], 1'b0};
            end
            default: begin
                a_idx = {1'b0, bf};
                tw_k  = bf;
            end
        endcase
        b_idx = a_idx | (3'd1 << stage);
    end

    // Twiddle ROM, W8^k in Q2.14
    always_comb begin
        w_re = 16'sd16384;
        w_im = 16'sd0;
        case (tw_k)
            2'd0: begin w_re =  16'sd16384; w_im =  16'sd0;     end
            2'd1: begin w_re =  16'sd11585; w_im = -16'sd11585; end
            2'd2: begin w_re =  16'sd0;     w_im = -16'sd16384; end
            default: begin w_re = -16'sd11585; w_im = -16'sd11585; end
        endcase
    end

    // Complex multiply b*W at 40 bits, then scale back by 2^14 with truncation
    always_comb begin
        a_re = mem_re_q[a_idx];
        a_im = mem_im_q[a_idx];
        b_re = mem_re_q[b_idx];
        b_im = mem_im_q[b_idx];
        t_re_full = 40'(b_re) * 40'(w_re) - 40'(b_im) * 40'(w_im);
        t_im_full = 40'(b_re) * 40'(w_im) + 40'(b_im) * 40'(w_re);
        t_re = 24'(t_re_full >>> 14);
        t_im = 24'(t_im_full >>> 14);
    end

    // Sequencer, RAM update and read port next-state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        finish_d  = finish_q;
        mem_re_d  = mem_re_q;
        mem_im_d  = mem_im_q;
        dout_re_d = mem_re_q[bus.read_addr];
        dout_im_d = mem_im_q[bus.read_addr];
        if (bus.initial_en) begin
            // start from IDLE/DONE, or abort a frame in progress
            state_d  = GAP;
            cnt_d    = 4'd0;
            finish_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                GAP: begin
                    state_d = LOAD;
                    cnt_d   = 4'd0;
                end
                LOAD: begin
                    mem_re_d[load_addr] = bus.datain_re;
                    mem_im_d[load_addr] = bus.datain_im;
                    if (cnt_q == 4'd7) begin
                        state_d = CALC;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                CALC: begin
                    mem_re_d[a_idx] = a_re + t_re;
                    mem_im_d[a_idx] = a_im + t_im;
                    mem_re_d[b_idx] = a_re - t_re;
                    mem_im_d[b_idx] = a_im - t_im;
                    if (cnt_q == 4'd11) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                DONE: finish_d = 1'b1;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, RAM and output registers; reset clears everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            finish_q  <= 1'b0;
            dout_re_q <= '0;
            dout_im_q <= '0;
            for (int i = 0; i < 8; i++) begin
                mem_re_q[i] <= '0;
                mem_im_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            finish_q  <= finish_d;
            dout_re_q <= dout_re_d;
            dout_im_q <= dout_im_d;
            mem_re_q  <= mem_re_d;
            mem_im_q  <= mem_im_d;
        end
    end

    assign bus.dataout_re = dout_re_q;
    assign bus.dataout_im = dout_im_q;
    assign bus.fft_finish = finish_q;

endmodule

// File: tb/tb_fft_top.sv
// Bench for fft_top: directed spectra plus random frames against an
// arithmetic FFT model.
module tb_fft_top;
    logic clk;
    logic rst;

    fft_if u_if ();

    fft_top u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    longint x_re [8];
    longint x_im [8];
    longint exp_re [8];
    longint exp_im [8];

    task automatic check_val(input string tag, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic longint wrap24(input longint v);
        logic signed [23:0] t;
        t = v[23:0];
        return longint'(t);
    endfunction

    // Reference: textbook iterative radix-2 FFT with Q2.14 twiddles and
    // truncating scale-back, results wrapped to 24 bits
    function automatic void ref_fft();
        longint ar [8];
        longint ai [8];
        longint wr [4];
        longint wi [4];
        wr = '{16384, 11585, 0, -11585};
        wi = '{0, -11585, -16384, -11585};
        for (int n = 0; n < 8; n++) begin
            int r;
            r = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
            ar[r] = x_re[n];
            ai[r] = x_im[n];
        end
        for (int s = 0; s < 3; s++) begin
            int h;
            h = 1 << s;
            for (int g = 0; g < 8; g += 2 * h) begin
                for (int p = 0; p < h; p++) begin
                    int k, ia, ib;
                    longint tr, ti, ra, rb, qa, qb;
                    k  = p * (4 / h);
                    ia = g + p;
                    ib = ia + h;
                    tr = (ar[ib] * wr[k] - ai[ib] * wi[k]) >>> 14;
                    ti = (ar[ib] * wi[k] + ai[ib] * wr[k]) >>> 14;
                    ra = wrap24(ar[ia] + tr);
                    qa = wrap24(ai[ia] + ti);
                    rb = wrap24(ar[ia] - tr);
                    qb = wrap24(ai[ia] - ti);
                    ar[ia] = ra; ai[ia] = qa;
                    ar[ib] = rb; ai[ib] = qb;
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            exp_re[k] = ar[k];
            exp_im[k] = ai[k];
        end
    endfunction

    function automatic longint rnd_sample();
        return longint'($urandom_range(0, 2097150)) - 64'sd1048575;
    endfunction

    // Start pulse at edge E; returns after E with fft_finish checked low
    task automatic start_pulse();
        @(negedge clk);
        u_if.initial_en = 1'b1;
        @(negedge clk);
        u_if.initial_en = 1'b0;
        check_val("fin_clr", longint'(u_if.fft_finish), 0);
    endtask

    // Stream x[0..7] on E+2..E+9, then measure edges until fft_finish
    task automatic feed_and_wait();
        int cyc;
        u_if.datain_re = 24'(rnd_sample());
        u_if.datain_im = 24'(rnd_sample());
        @(negedge clk);
        for (int n = 0; n < 8; n++) begin
            u_if.datain_re = 24'(x_re[n]);
            u_if.datain_im = 24'(x_im[n]);
            @(negedge clk);
        end
        u_if.datain_re = 24'(rnd_sample());
        u_if.datain_im = 24'(rnd_sample());
        cyc = 9;
        while (!u_if.fft_finish && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check_val("fin_lat", cyc, 22);
    endtask

    // Walk read_addr 0..7; each result must appear exactly one edge later
    task automatic sweep_check(input string tag);
        @(negedge clk);
        u_if.read_addr = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            u_if.read_addr = 3'(k % 8);
            #1;
            check_val($sformatf("%s_re%0d", tag, k - 1), longint'(u_if.dataout_re), exp_re[k - 1]);
            check_val($sformatf("%s_im%0d", tag, k - 1), longint'(u_if.dataout_im), exp_im[k - 1]);
        end
    endtask

    task automatic set_dc();
        for (int n = 0; n < 8; n++) begin
            x_re[n] = 1000; x_im[n] = 0;
            exp_re[n] = (n == 0) ? 8000 : 0; exp_im[n] = 0;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0;
        u_if.initial_en = 1'b0;
        u_if.datain_re  = '0;
        u_if.datain_im  = '0;
        u_if.read_addr  = 3'd0;
        repeat (3) @(negedge clk);
        check_val("rst_fin", longint'(u_if.fft_finish), 0);
        check_val("rst_dre", longint'(u_if.dataout_re), 0);
        check_val("rst_dim", longint'(u_if.dataout_im), 0);
        rst = 1'b1;
        @(negedge clk);

        // impulse
        for (int n = 0; n < 8; n++) begin
            x_re[n] = (n == 0) ? 1000 : 0; x_im[n] = 0;
            exp_re[n] = 1000; exp_im[n] = 0;
        end
        start_pulse();
        feed_and_wait();
        sweep_check("imp");

        // DC, restarted from DONE: fft_finish must drop at the start edge
        check_val("fin_hold", longint'(u_if.fft_finish), 1);
        set_dc();
        start_pulse();
        feed_and_wait();
        sweep_check("dc");

        // alternating sign
        for (int n = 0; n < 8; n++) begin
            x_re[n] = (n % 2 == 0) ? 1000 : -1000; x_im[n] = 0;
            exp_re[n] = (n == 4) ? 8000 : 0; exp_im[n] = 0;
        end
        start_pulse();
        feed_and_wait();
        sweep_check("alt");

        // cosine at bin 1: exact against model, and within 2 LSB of ideal
        x_re = '{1000, 707, 0, -707, -1000, -707, 0, 707};
        x_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        ref_fft();
        start_pulse();
        feed_and_wait();
        sweep_check("cos");
        for (int k = 0; k < 8; k++) begin
            longint ideal, dr, di;
            ideal = (k == 1 || k == 7) ? 4000 : 0;
            @(negedge clk);
            u_if.read_addr = 3'(k);
            @(negedge clk);
            dr = longint'(u_if.dataout_re) - ideal;
            di = longint'(u_if.dataout_im);
            check_val($sformatf("cos_tol%0d", k),
                      longint'(dr >= -2 && dr <= 2 && di >= -2 && di <= 2), 1);
        end

        // random frames
        for (int f = 0; f < 4; f++) begin
            for (int n = 0; n < 8; n++) begin
                x_re[n] = rnd_sample();
                x_im[n] = rnd_sample();
            end
            ref_fft();
            start_pulse();
            feed_and_wait();
            sweep_check($sformatf("rnd%0d", f));
        end

        // abort mid-LOAD, then a clean random frame must come out right
        start_pulse();
        repeat (5) begin
            @(negedge clk);
            u_if.datain_re = 24'(rnd_sample());
            u_if.datain_im = 24'(rnd_sample());
        end
        for (int n = 0; n < 8; n++) begin
            x_re[n] = rnd_sample();
            x_im[n] = rnd_sample();
        end
        ref_fft();
        start_pulse();
        feed_and_wait();
        sweep_check("abort");

        // reset in the middle of CALC
        set_dc();
        u_if.read_addr = 3'd0;
        start_pulse();
        @(negedge clk);
        for (int n = 0; n < 8; n++) begin
            u_if.datain_re = 24'(x_re[n]);
            u_if.datain_im = 24'(x_im[n]);
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_val("mid_rst_fin", longint'(u_if.fft_finish), 0);
        check_val("mid_rst_dre", longint'(u_if.dataout_re), 0);
        check_val("mid_rst_dim", longint'(u_if.dataout_im), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("post_rst_dre", longint'(u_if.dataout_re), 0);
        check_val("post_rst_fin", longint'(u_if.fft_finish), 0);
        set_dc();
        start_pulse();
        feed_and_wait();
        sweep_check("dc2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, finish not seen");
        $fatal(1, "watchdog");
    end

endmodule
